// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: owns PC and IR, fetches over a req/ack handshake
// and selects the next PC from the control unit's write controls.
module busca_instrucao #(
   parameter int unsigned          LARG_PC    = 8,
   parameter int unsigned          LARG_INSTR = 16,
   parameter logic [LARG_PC-1:0]   PC_RESET   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  mem_req,
   output logic [LARG_PC-1:0]    mem_addr,
   input  logic                  mem_ack,
   input  logic [LARG_INSTR-1:0] mem_dado,
   input  logic                  EscCP,
   input  logic                  EscCondCP,
   input  logic [1:0]            FonteCP,
   input  logic                  zero,
   input  logic [LARG_PC-1:0]    alvo_ula,
   output logic [LARG_PC-1:0]    PC,
   output logic [LARG_INSTR-1:0] IR,
   output logic [3:0]            opcode,
   output logic                  instr_valida,
   output logic                  parado
);

   typedef enum logic [2:0] {
      INICIO,
      BUSCA,
      DECOD,
      EXEC,
      PARADO
   } estado_t;

   estado_t               estado_q;
   logic [LARG_PC-1:0]    pc_q;
   logic [LARG_PC-1:0]    pc_d;
   logic [LARG_PC-1:0]    pc_seq;
   logic [LARG_INSTR-1:0] ir_q;
   logic                  escreve_pc;

   assign pc_seq = pc_q + 1'b1;

   // A conditional write always updates PC: taken branch or fall-through.
   always_comb begin
      pc_d       = pc_seq;
      escreve_pc = 1'b1;
      if (EscCondCP) begin
         pc_d = zero ? alvo_ula : pc_seq;
      end else if (EscCP) begin
         unique case (FonteCP)
            2'b01:   pc_d = alvo_ula;
            2'b10:   pc_d = ir_q[LARG_PC-1:0];
            default: pc_d = pc_seq;
         endcase
      end else begin
         pc_d       = pc_q;
         escreve_pc = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q <= INICIO;
         pc_q     <= PC_RESET;
         ir_q     <= '0;
      end else begin
         unique case (estado_q)
            INICIO: estado_q <= BUSCA;
            BUSCA: begin
               if (mem_ack) begin
                  ir_q     <= mem_dado;
                  estado_q <= DECOD;
               end
            end
            DECOD: estado_q <= EXEC;
            EXEC: begin
               pc_q     <= pc_d;
               estado_q <= escreve_pc ? BUSCA : PARADO;
            end
            PARADO: estado_q <= PARADO;
            default: estado_q <= INICIO;
         endcase
      end
   end

   assign mem_req      = (estado_q == BUSCA);
   assign mem_addr     = pc_q;
   assign PC           = pc_q;
   assign IR           = ir_q;
   assign opcode       = ir_q[LARG_INSTR-1 -: 4];
   assign instr_valida = (estado_q == DECOD);
   assign parado       = (estado_q == PARADO);

endmodule
